// File: rtl/ex_mem_stage_pkg.sv
//==============================================================================
// Module  : ex_mem_stage_pkg
// Brief   : Shared ALU operation codes, memory size codes and redirect helper
//           for the execute / EX-MEM pipeline stage.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package ex_mem_stage_pkg;

   localparam int ALU_CTRL_W = 4;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

   // Memory access size codes carried through to the memory stage untouched
   typedef enum logic [1:0] {
      MEM_NONE = 2'd0,
      MEM_BYTE = 2'd1,
      MEM_HALF = 2'd2,
      MEM_WORD = 2'd3
   } mem_size_e;

   function automatic logic redirect_taken(input logic jump,
                                           input logic branch,
                                           input logic alu_zero);
      return jump | (branch & alu_zero);
   endfunction

endpackage : ex_mem_stage_pkg

`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
//==============================================================================
// Module  : ex_mem_stage_if
// Brief   : ID/EX inputs, MEM/WB forwarding inputs and EX/MEM outputs of the
//           execute stage, bundled for the stage and its upstream driver.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface ex_mem_stage_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] id_src1;
   logic [REG_ADDR_W-1:0] id_src2;
   logic [REG_ADDR_W-1:0] id_dest;
   logic [DATA_W-1:0]     id_reg1;
   logic [DATA_W-1:0]     id_reg2;
   logic [DATA_W-1:0]     id_imm;
   logic                  id_alu_src;
   logic [3:0]            id_alu_ctrl;
   logic                  id_reg_write;
   logic                  id_mem_to_reg;
   logic [1:0]            id_mem_read;
   logic [1:0]            id_mem_write;
   logic                  id_branch;
   logic                  id_jump;
   logic [DATA_W-1:0]     id_branch_target;
   logic [DATA_W-1:0]     id_jump_target;

   logic [REG_ADDR_W-1:0] wb_dest;
   logic                  wb_reg_write;
   logic [DATA_W-1:0]     wb_data;

   logic [DATA_W-1:0]     mem_alu_result;
   logic [DATA_W-1:0]     mem_store_data;
   logic [REG_ADDR_W-1:0] mem_dest;
   logic                  mem_reg_write;
   logic                  mem_mem_to_reg;
   logic [1:0]            mem_mem_read;
   logic [1:0]            mem_mem_write;
   logic                  redirect;
   logic [DATA_W-1:0]     redirect_target;

   modport master (
      output id_src1, id_src2, id_dest, id_reg1, id_reg2, id_imm,
             id_alu_src, id_alu_ctrl, id_reg_write, id_mem_to_reg,
             id_mem_read, id_mem_write, id_branch, id_jump,
             id_branch_target, id_jump_target,
             wb_dest, wb_reg_write, wb_data,
      input  mem_alu_result, mem_store_data, mem_dest, mem_reg_write,
             mem_mem_to_reg, mem_mem_read, mem_mem_write,
             redirect, redirect_target
   );

   modport slave (
      input  id_src1, id_src2, id_dest, id_reg1, id_reg2, id_imm,
             id_alu_src, id_alu_ctrl, id_reg_write, id_mem_to_reg,
             id_mem_read, id_mem_write, id_branch, id_jump,
             id_branch_target, id_jump_target,
             wb_dest, wb_reg_write, wb_data,
      output mem_alu_result, mem_store_data, mem_dest, mem_reg_write,
             mem_mem_to_reg, mem_mem_read, mem_mem_write,
             redirect, redirect_target
   );
endinterface : ex_mem_stage_if

`default_nettype wire

// File: rtl/ex_alu.sv
//==============================================================================
// Module  : ex_alu
// Brief   : Combinational MIPS ALU (AND/OR/ADD/SUB/SLT/NOR) with zero flag.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_alu
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   input  logic [ALU_CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0]     result,
   output logic                  zero
);

   always_comb begin
      result = '0;
      case (ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_NOR: result = ~(a | b);
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule : ex_alu

`default_nettype wire

// File: rtl/ex_mem_stage.sv
//==============================================================================
// Module  : ex_mem_stage
// Brief   : Execute stage with operand forwarding, branch/jump resolution and
//           the EX/MEM pipeline register, including wrong-path squash.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           stall,
   ex_mem_stage_if.slave  bus
);

   logic [DATA_W-1:0]     alu_result_q, alu_result_d;
   logic [DATA_W-1:0]     store_data_q, store_data_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   logic                  reg_write_q, reg_write_d;
   logic                  mem_to_reg_q, mem_to_reg_d;
   logic [1:0]            mem_read_q, mem_read_d;
   logic [1:0]            mem_write_q, mem_write_d;
   logic                  redirect_q, redirect_d;
   logic [DATA_W-1:0]     redirect_target_q, redirect_target_d;

   logic [DATA_W-1:0]     fwd_a;
   logic [DATA_W-1:0]     fwd_b;
   logic [DATA_W-1:0]     alu_b;
   logic [DATA_W-1:0]     alu_result;
   logic                  alu_zero;
   logic                  take_redirect;
   logic [DATA_W-1:0]     new_target;

   // A load sitting in EX/MEM has no data yet, so it is never a forwarding source
   always_comb begin
      fwd_a = bus.id_reg1;
      if (bus.id_src1 != '0) begin
         if (reg_write_q && !mem_to_reg_q && (dest_q == bus.id_src1))
            fwd_a = alu_result_q;
         else if (bus.wb_reg_write && (bus.wb_dest == bus.id_src1))
            fwd_a = bus.wb_data;
      end
   end

   always_comb begin
      fwd_b = bus.id_reg2;
      if (bus.id_src2 != '0) begin
         if (reg_write_q && !mem_to_reg_q && (dest_q == bus.id_src2))
            fwd_b = alu_result_q;
         else if (bus.wb_reg_write && (bus.wb_dest == bus.id_src2))
            fwd_b = bus.wb_data;
      end
   end

   assign alu_b = bus.id_alu_src ? bus.id_imm : fwd_b;

   ex_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (fwd_a),
      .b      (alu_b),
      .ctrl   (bus.id_alu_ctrl),
      .result (alu_result),
      .zero   (alu_zero)
   );

   always_comb begin
      take_redirect = redirect_taken(bus.id_jump, bus.id_branch, alu_zero);
      new_target    = '0;
      if (bus.id_jump)
         new_target = bus.id_jump_target;
      else if (bus.id_branch && alu_zero)
         new_target = bus.id_branch_target;
   end

   // Stall holds everything; an outstanding redirect turns the next capture into a bubble
   always_comb begin
      alu_result_d      = alu_result_q;
      store_data_d      = store_data_q;
      dest_d            = dest_q;
      reg_write_d       = reg_write_q;
      mem_to_reg_d      = mem_to_reg_q;
      mem_read_d        = mem_read_q;
      mem_write_d       = mem_write_q;
      redirect_d        = redirect_q;
      redirect_target_d = redirect_target_q;
      if (!stall) begin
         if (redirect_q) begin
            alu_result_d      = '0;
            store_data_d      = '0;
            dest_d            = '0;
            reg_write_d       = 1'b0;
            mem_to_reg_d      = 1'b0;
            mem_read_d        = '0;
            mem_write_d       = '0;
            redirect_d        = 1'b0;
            redirect_target_d = '0;
         end else begin
            alu_result_d      = alu_result;
            store_data_d      = fwd_b;
            dest_d            = bus.id_dest;
            reg_write_d       = bus.id_reg_write;
            mem_to_reg_d      = bus.id_mem_to_reg;
            mem_read_d        = bus.id_mem_read;
            mem_write_d       = bus.id_mem_write;
            redirect_d        = take_redirect;
            redirect_target_d = new_target;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result_q      <= '0;
         store_data_q      <= '0;
         dest_q            <= '0;
         reg_write_q       <= 1'b0;
         mem_to_reg_q      <= 1'b0;
         mem_read_q        <= '0;
         mem_write_q       <= '0;
         redirect_q        <= 1'b0;
         redirect_target_q <= '0;
      end else begin
         alu_result_q      <= alu_result_d;
         store_data_q      <= store_data_d;
         dest_q            <= dest_d;
         reg_write_q       <= reg_write_d;
         mem_to_reg_q      <= mem_to_reg_d;
         mem_read_q        <= mem_read_d;
         mem_write_q       <= mem_write_d;
         redirect_q        <= redirect_d;
         redirect_target_q <= redirect_target_d;
      end
   end

   assign bus.mem_alu_result  = alu_result_q;
   assign bus.mem_store_data  = store_data_q;
   assign bus.mem_dest        = dest_q;
   assign bus.mem_reg_write   = reg_write_q;
   assign bus.mem_mem_to_reg  = mem_to_reg_q;
   assign bus.mem_mem_read    = mem_read_q;
   assign bus.mem_mem_write   = mem_write_q;
   assign bus.redirect        = redirect_q;
   assign bus.redirect_target = redirect_target_q;

endmodule : ex_mem_stage

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
//==============================================================================
// Module  : tb_ex_mem_stage
// Brief   : Self-checking bench for ex_mem_stage: ALU vector table plus
//           forwarding, redirect/squash, stall and reset sequences.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ex_mem_stage;
   import ex_mem_stage_pkg::*;

   logic clk;
   logic rst;
   logic stall;

   ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

   ex_mem_stage #(
      .DATA_W     (32),
      .REG_ADDR_W (5)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] store;
      logic [4:0]  dest;
      logic        rw;
      logic        m2r;
      logic [1:0]  mr;
      logic [1:0]  mw;
      logic        rd;
      logic [31:0] tgt;
   } exp_t;

   typedef struct {
      string       name;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[10];
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t zero_e;
   exp_t held_e;

   function automatic exp_t mk(logic [31:0] alu, logic [31:0] store, logic [4:0] dest,
                               logic rw, logic m2r, logic [1:0] mr, logic [1:0] mw,
                               logic rd, logic [31:0] tgt);
      exp_t e;
      e.alu = alu; e.store = store; e.dest = dest; e.rw = rw; e.m2r = m2r;
      e.mr = mr; e.mw = mw; e.rd = rd; e.tgt = tgt;
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // Pops the oldest expectation and compares it with what the DUT shows now
   task automatic check_now(string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %h expected an entry", tag, 0);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".alu"},    bus.mem_alu_result,          e.alu);
      chk({tag, ".store"},  bus.mem_store_data,          e.store);
      chk({tag, ".dest"},   {27'd0, bus.mem_dest},       {27'd0, e.dest});
      chk({tag, ".rw"},     {31'd0, bus.mem_reg_write},  {31'd0, e.rw});
      chk({tag, ".m2r"},    {31'd0, bus.mem_mem_to_reg}, {31'd0, e.m2r});
      chk({tag, ".mr"},     {30'd0, bus.mem_mem_read},   {30'd0, e.mr});
      chk({tag, ".mw"},     {30'd0, bus.mem_mem_write},  {30'd0, e.mw});
      chk({tag, ".rd"},     {31'd0, bus.redirect},       {31'd0, e.rd});
      chk({tag, ".tgt"},    bus.redirect_target,         e.tgt);
   endtask

   task automatic step(string tag, exp_t e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_now(tag);
   endtask

   task automatic clr();
      bus.id_src1 = '0; bus.id_src2 = '0; bus.id_dest = '0;
      bus.id_reg1 = '0; bus.id_reg2 = '0; bus.id_imm = '0;
      bus.id_alu_src = 1'b0; bus.id_alu_ctrl = ALU_ADD;
      bus.id_reg_write = 1'b0; bus.id_mem_to_reg = 1'b0;
      bus.id_mem_read = MEM_NONE; bus.id_mem_write = MEM_NONE;
      bus.id_branch = 1'b0; bus.id_jump = 1'b0;
      bus.id_branch_target = '0; bus.id_jump_target = '0;
      bus.wb_dest = '0; bus.wb_reg_write = 1'b0; bus.wb_data = '0;
   endtask

   initial begin
      zero_e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0] = '{"slt_neg",  ALU_SLT, 32'hFFFF_FFFF, 32'h1,         32'h1};
      tbl[1] = '{"slt_pos",  ALU_SLT, 32'h1,         32'hFFFF_FFFF, 32'h0};
      tbl[2] = '{"add_ovf",  ALU_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000};
      tbl[3] = '{"bad_ctrl", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0};
      tbl[4] = '{"and",      ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
      tbl[5] = '{"or",       ALU_OR,  32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011};
      tbl[6] = '{"nor",      ALU_NOR, 32'hF000_0001, 32'h0F00_0010, 32'h00FF_FFEE};
      tbl[7] = '{"sub_wrap", ALU_SUB, 32'h0,         32'h1,         32'hFFFF_FFFF};
      tbl[8] = '{"add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h2,         32'h1};
      tbl[9] = '{"slt_eq",   ALU_SLT, 32'h8000_0000, 32'h8000_0000, 32'h0};

      rst = 1'b0; stall = 1'b0;
      clr();
      #1 rst = 1'b1;
      #1;
      sb.push_back(zero_e);
      check_now("reset_state");
      #6 rst = 1'b0;

      // ALU table with no forwarding sources in play
      for (int i = 0; i < 10; i++) begin
         clr();
         bus.id_alu_ctrl = tbl[i].ctrl;
         bus.id_reg1     = tbl[i].a;
         bus.id_reg2     = tbl[i].b;
         step(tbl[i].name, mk(tbl[i].exp, tbl[i].b, 0, 0, 0, 0, 0, 0, 0));
      end

      // EX/MEM beats MEM/WB
      clr();
      bus.id_reg1 = 32'h10; bus.id_dest = 5'd3; bus.id_reg_write = 1'b1;
      step("fwd_setup", mk(32'h10, 0, 3, 1, 0, 0, 0, 0, 0));
      clr();
      bus.id_src1 = 5'd3; bus.id_reg1 = 32'h99; bus.id_reg2 = 32'h1;
      bus.wb_dest = 5'd3; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h55;
      bus.id_dest = 5'd4; bus.id_reg_write = 1'b1;
      step("fwd_prio", mk(32'h11, 32'h1, 4, 1, 0, 0, 0, 0, 0));
      clr();
      bus.id_src1 = 5'd5; bus.id_reg1 = 32'h99; bus.id_alu_ctrl = ALU_OR;
      bus.wb_dest = 5'd5; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h55;
      bus.id_dest = 5'd6; bus.id_reg_write = 1'b1;
      step("fwd_wb", mk(32'h55, 0, 6, 1, 0, 0, 0, 0, 0));
      clr();
      bus.id_src2 = 5'd6; bus.id_reg2 = 32'hAAAA;
      bus.id_dest = 5'd7; bus.id_reg_write = 1'b1;
      step("fwd_b_mem", mk(32'h55, 32'h55, 7, 1, 0, 0, 0, 0, 0));
      clr();
      bus.id_src2 = 5'd7; bus.id_reg2 = 32'h1; bus.id_reg1 = 32'h2;
      bus.id_imm = 32'h100; bus.id_alu_src = 1'b1; bus.id_mem_write = MEM_WORD;
      step("imm_store", mk(32'h102, 32'h55, 0, 0, 0, 0, 3, 0, 0));

      // r0 never forwarded; load in EX/MEM never forwarded
      clr();
      bus.id_reg1 = 32'h9; bus.wb_dest = 5'd0; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h5;
      bus.id_dest = 5'd8; bus.id_reg_write = 1'b1; bus.id_mem_to_reg = 1'b1;
      bus.id_mem_read = MEM_WORD;
      step("r0", mk(32'h9, 0, 8, 1, 1, 3, 0, 0, 0));
      clr();
      bus.id_src1 = 5'd8; bus.id_reg1 = 32'h20; bus.id_alu_ctrl = ALU_OR;
      bus.wb_dest = 5'd8; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h33;
      bus.id_dest = 5'd9; bus.id_reg_write = 1'b1; bus.id_mem_to_reg = 1'b1;
      bus.id_mem_read = MEM_HALF;
      step("load_to_wb", mk(32'h33, 0, 9, 1, 1, 2, 0, 0, 0));
      clr();
      bus.id_src1 = 5'd9; bus.id_reg1 = 32'h44; bus.id_alu_ctrl = ALU_OR;
      step("load_to_id", mk(32'h44, 0, 0, 0, 0, 0, 0, 0, 0));

      // Taken branch, squashed follower, then normal capture
      clr();
      bus.id_alu_ctrl = ALU_SUB; bus.id_reg1 = 32'h7; bus.id_reg2 = 32'h7;
      bus.id_branch = 1'b1; bus.id_branch_target = 32'h40;
      step("br_taken", mk(0, 32'h7, 0, 0, 0, 0, 0, 1, 32'h40));
      clr();
      bus.id_reg1 = 32'h1; bus.id_reg2 = 32'h1; bus.id_dest = 5'd5;
      bus.id_reg_write = 1'b1; bus.id_mem_write = MEM_HALF;
      step("br_squash", zero_e);
      clr();
      bus.id_reg1 = 32'h3; bus.id_reg2 = 32'h4; bus.id_dest = 5'd2; bus.id_reg_write = 1'b1;
      step("br_after", mk(32'h7, 32'h4, 2, 1, 0, 0, 0, 0, 0));
      clr();
      bus.id_alu_ctrl = ALU_SUB; bus.id_reg1 = 32'h7; bus.id_reg2 = 32'h8;
      bus.id_branch = 1'b1; bus.id_branch_target = 32'h40;
      step("br_not", mk(32'hFFFF_FFFF, 32'h8, 0, 0, 0, 0, 0, 0, 0));

      // Jump wins over an also-taken branch; then stall while redirect is up
      clr();
      bus.id_alu_ctrl = ALU_SUB; bus.id_reg1 = 32'h7; bus.id_reg2 = 32'h7;
      bus.id_branch = 1'b1; bus.id_branch_target = 32'h40;
      bus.id_jump = 1'b1; bus.id_jump_target = 32'h80;
      held_e = mk(0, 32'h7, 0, 0, 0, 0, 0, 1, 32'h80);
      step("jump", held_e);
      clr();
      stall = 1'b1;
      bus.id_reg1 = 32'h5; bus.id_dest = 5'd11; bus.id_reg_write = 1'b1;
      bus.id_mem_write = MEM_HALF;
      step("stall1", held_e);
      step("stall2", held_e);
      stall = 1'b0;
      step("stall_bubble", zero_e);
      step("stall_resume", mk(32'h5, 0, 11, 1, 0, 0, 2, 0, 0));

      // Asynchronous reset with a redirect and live instruction in flight
      clr();
      bus.id_jump = 1'b1; bus.id_jump_target = 32'hC0; bus.id_reg1 = 32'h6;
      bus.id_reg2 = 32'h2; bus.id_dest = 5'd9; bus.id_reg_write = 1'b1;
      bus.id_mem_write = MEM_WORD;
      step("pre_reset", mk(32'h8, 32'h2, 9, 1, 0, 0, 3, 1, 32'hC0));
      #2 rst = 1'b1;
      #1;
      sb.push_back(zero_e);
      check_now("reset_async");
      step("reset_hold", zero_e);
      rst = 1'b0;
      clr();
      bus.id_reg1 = 32'h21; bus.id_reg2 = 32'h1; bus.id_dest = 5'd12; bus.id_reg_write = 1'b1;
      step("post_reset", mk(32'h22, 32'h1, 12, 1, 0, 0, 0, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ex_mem_stage

`default_nettype wire
